// File: rtl/scpu_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// scpu_fetch_unit_pkg
// Shared definitions for the instruction-fetch stage and the control decoder:
//   - fetch FSM state encoding (BOOT / FETCH / EXEC)
//   - 2-bit Branch select constants produced by the decoder
//   - default reset PC and misaligned-jump trap vector
//   - branch offset helper (sign-extended word offset, byte aligned)
// ---------------------------------------------------------------------------
package scpu_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } fetch_state_e;

  localparam logic [1:0] BR_SEQ    = 2'b00;
  localparam logic [1:0] BR_BRANCH = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;
  localparam logic [1:0] BR_REG    = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0008;

  // Sign-extend a 16-bit word displacement and convert it to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/scpu_fetch_unit_next_pc.sv
// ---------------------------------------------------------------------------
// scpu_next_pc
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc         in  32  address of the current instruction
//   inst       in  26  low 26 bits of the instruction register
//   Branch     in   2  next-PC select from the decoder
//   rs_data    in  32  register-jump target
//   next_pc    out 32  PC of the following instruction (before trapping)
//   pc_plus4   out 32  sequential successor / link value
//   misaligned out  1  register-jump target is not word aligned
// ---------------------------------------------------------------------------
module scpu_next_pc
  import scpu_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [1:0]  Branch,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] seq_pc_s;

  // Sequential successor; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  assign seq_pc_s = pc + 32'd4;
  assign pc_plus4 = seq_pc_s;

  // Select the successor PC and flag misaligned register jumps.
  always_comb begin
    next_pc    = seq_pc_s;
    misaligned = 1'b0;
    case (Branch)
      BR_SEQ: begin
        next_pc = seq_pc_s;
      end
      BR_BRANCH: begin
        next_pc = seq_pc_s + branch_offset(inst[15:0]);
      end
      BR_JUMP: begin
        // Region bits come from pc+4, not pc, so a jump in the last slot of a
        // 256 MB region lands in the next region.
        next_pc = {seq_pc_s[31:28], inst[25:0], 2'b00};
      end
      BR_REG: begin
        next_pc = rs_data;
        if (rs_data[1:0] != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          misaligned = 1'b0;
        end
      end
      default: begin
        next_pc    = seq_pc_s;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/scpu_fetch_unit.sv
// ---------------------------------------------------------------------------
// scpu_fetch_unit
// Instruction fetch and PC sequencing stage ahead of the single-cycle control
// decoder. Fetches one word per instruction over a ready handshake, holds it
// in the instruction register while it executes, and advances the PC on
// commit according to the decoder's Branch select. Misaligned register-jump
// targets are redirected to EXC_VECTOR with a one-cycle exc pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr/imem_req       fetch address (= pc) and request (FETCH state)
//   imem_data/imem_ready     instruction word and its handshake
//   inst/inst_valid          instruction register and its execute flag
//   commit                   instruction retires this cycle (EXEC & MIO_ready)
//   Branch/rs_data           next-PC select and register-jump target
//   MIO_ready                data memory ready; low stretches execution
//   pc/pc_plus4              current PC and link value
//   exc                      misaligned register jump trapped (1 cycle)
//   retired                  retired-instruction counter
// ---------------------------------------------------------------------------
module scpu_fetch_unit
  import scpu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        commit,
  input  logic [1:0]  Branch,
  input  logic [31:0] rs_data,
  input  logic        MIO_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exc,
  output logic [31:0] retired
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  retired_q, retired_d;
  logic         exc_q, exc_d;

  logic [31:0]  next_pc_s;
  logic [31:0]  pc_plus4_s;
  logic         misaligned_s;
  logic         commit_s;

  scpu_next_pc u_next_pc (
    .pc         (pc_q),
    .inst       (inst_q[25:0]),
    .Branch     (Branch),
    .rs_data    (rs_data),
    .next_pc    (next_pc_s),
    .pc_plus4   (pc_plus4_s),
    .misaligned (misaligned_s)
  );

  assign commit_s = (state_q == ST_EXEC) & MIO_ready;

  // Next-state, PC, instruction register, counter and trap-flag update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    exc_d     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_data;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (commit_s) begin
          state_d   = ST_FETCH;
          retired_d = retired_q + 32'd1;
          if (misaligned_s) begin
            pc_d  = EXC_VECTOR;
            exc_d = 1'b1;
          end else begin
            pc_d  = next_pc_s;
            exc_d = 1'b0;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0000;
      retired_q <= 32'h0000_0000;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      exc_q     <= exc_d;
    end
  end

  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == ST_FETCH);
  assign inst       = inst_q;
  assign inst_valid = (state_q == ST_EXEC);
  assign commit     = commit_s;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_s;
  assign exc        = exc_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_scpu_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_scpu_fetch_unit
// Directed bench for the fetch stage. Expected PCs are produced by a small
// reference model when an instruction commits and pushed to a queue; they are
// popped and compared when the DUT presents the next fetch address.
// ---------------------------------------------------------------------------
module tb_scpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        commit;
  logic [1:0]  Branch;
  logic [31:0] rs_data;
  logic        MIO_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exc;
  logic [31:0] retired;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_commit = 0;
  logic [31:0] pc_sb[$];
  logic [31:0] exp_ret;

  scpu_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .commit     (commit),
    .Branch     (Branch),
    .rs_data    (rs_data),
    .MIO_ready  (MIO_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exc        (exc),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next-PC model; ex reports a trapped register jump.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic [1:0] br, input logic [31:0] rs,
                                             output logic ex);
    logic [31:0] seq;
    logic [31:0] off;
    logic [31:0] res;
    seq = p + 32'd4;
    ex  = 1'b0;
    off = {{16{w[15]}}, w[15:0]};
    case (br)
      2'b00:   res = seq;
      2'b01:   res = seq + (off << 2);
      2'b10:   res = {seq[31:28], w[25:0], 2'b00};
      default: begin
        if (rs[1:0] != 2'b00) begin
          ex  = 1'b1;
          res = 32'h0000_0008;
        end else begin
          res = rs;
        end
      end
    endcase
    return res;
  endfunction

  // Fetch one instruction (optional imem stall), execute it (optional data
  // memory stall), commit with the given Branch/rs_data and check the result.
  task automatic run_instr(input logic [31:0] word, input logic [1:0] br,
                           input logic [31:0] rs, input int f_stall,
                           input int m_stall, input bit chk_tp);
    int          n;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
    logic        exp_exc;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("fetch_wait", {31'd0, imem_req}, 32'd1);
    if (pc_sb.size() > 0) exp_pc = pc_sb.pop_front();
    else exp_pc = 32'hDEAD_BEEF;
    check("imem_addr", imem_addr, exp_pc);
    repeat (f_stall) begin
      imem_ready = 1'b0;
      imem_data  = $urandom;
      @(negedge clk);
      check("fetch_hold_addr", imem_addr, exp_pc);
      check("fetch_hold_req", {31'd0, imem_req}, 32'd1);
      check("fetch_hold_commit", {31'd0, commit}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_data  = word;
    #1;
    check("fetch_commit", {31'd0, commit}, 32'd0);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_data  = $urandom;
    check("exec_valid", {31'd0, inst_valid}, 32'd1);
    check("exec_req", {31'd0, imem_req}, 32'd0);
    check("exec_inst", inst, word);
    check("exec_pc", pc, exp_pc);
    check("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    check("exec_exc_clear", {31'd0, exc}, 32'd0);
    repeat (m_stall) begin
      MIO_ready = 1'b0;
      Branch    = 2'($urandom);
      rs_data   = $urandom;
      #1;
      check("stall_commit", {31'd0, commit}, 32'd0);
      @(negedge clk);
      check("stall_inst", inst, word);
      check("stall_pc", pc, exp_pc);
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
    end
    MIO_ready = 1'b1;
    Branch    = br;
    rs_data   = rs;
    #1;
    check("commit", {31'd0, commit}, 32'd1);
    if (chk_tp) check("throughput", 32'(cyc - last_commit), 32'd2);
    last_commit = cyc;
    exp_next = model_next(exp_pc, word, br, rs, exp_exc);
    pc_sb.push_back(exp_next);
    exp_ret = exp_ret + 32'd1;
    @(negedge clk);
    MIO_ready = 1'b0;
    Branch    = 2'($urandom);
    rs_data   = $urandom;
    check("post_exc", {31'd0, exc}, {31'd0, exp_exc});
    check("post_retired", retired, exp_ret);
    check("post_pc", pc, exp_next);
    check("post_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ready = 1'b0;
    imem_data  = 32'h0000_0000;
    Branch     = 2'b00;
    rs_data    = 32'h0000_0000;
    MIO_ready  = 1'b0;
    exp_ret    = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    check("rst_inst", inst, 32'h0000_0000);
    check("rst_retired", retired, 32'h0000_0000);
    check("rst_exc", {31'd0, exc}, 32'd0);

    // BOOT cycle, then first request in the second cycle after reset
    rst = 1'b0;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    pc_sb.push_back(32'h0000_0000);

    // Sequential stream at full throughput: 0, 4, 8
    run_instr(32'h2001_0001, 2'b00, 32'h0, 0, 0, 1'b0);
    run_instr(32'h2002_0002, 2'b00, 32'h0, 0, 0, 1'b1);
    run_instr(32'h2003_0003, 2'b00, 32'h0, 0, 0, 1'b1);
    check("retired_three", retired, 32'd3);

    // Conditional branches from 0x10: back to 0x0C, then forward to 0x20
    run_instr(32'h0000_0000, 2'b00, 32'h0, 0, 0, 1'b0);
    run_instr(32'h1000_FFFE, 2'b01, 32'h0, 0, 0, 1'b0);
    run_instr(32'h0000_0000, 2'b00, 32'h0, 0, 0, 1'b0);
    run_instr(32'h1000_0003, 2'b01, 32'h0, 0, 0, 1'b0);

    // Register jump to 0x4000_0000, then absolute jump to 0x4000_0100
    run_instr(32'h0000_0008, 2'b11, 32'h4000_0000, 0, 0, 1'b0);
    run_instr(32'h0800_0040, 2'b10, 32'h0, 0, 0, 1'b0);

    // Aligned register jump, then misaligned one that traps to 0x08
    run_instr(32'h0000_0008, 2'b11, 32'h0000_0104, 0, 0, 1'b0);
    run_instr(32'h0000_0009, 2'b11, 32'h0000_0106, 0, 0, 1'b0);

    // imem not ready for 3 cycles, data memory not ready for 2 cycles
    run_instr(32'h8C01_0004, 2'b00, 32'h0, 3, 2, 1'b0);

    // PC wrap: jump to 0xFFFF_FFFC, sequential successor is 0
    run_instr(32'h0000_0008, 2'b11, 32'hFFFF_FFFC, 0, 0, 1'b0);
    run_instr(32'h0000_0000, 2'b00, 32'h0, 0, 0, 1'b0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset while an instruction is committing
    begin
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("rst_exec_wait", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      imem_data  = 32'h0800_1234;
      @(negedge clk);
      imem_ready = 1'b0;
      check("rst_exec_valid", {31'd0, inst_valid}, 32'd1);
      MIO_ready = 1'b1;
      Branch    = 2'b10;
      rst       = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      MIO_ready = 1'b0;
      check("rst_exec_retired", retired, 32'd0);
      check("rst_exec_pc", pc, 32'h0000_0000);
      check("rst_exec_inst", inst, 32'h0000_0000);
      check("rst_exec_req", {31'd0, imem_req}, 32'd0);
      check("rst_exec_valid0", {31'd0, inst_valid}, 32'd0);
      pc_sb.delete();
      pc_sb.push_back(32'h0000_0000);
      exp_ret = 32'd0;
      @(negedge clk);
      check("rst_exec_refetch", {31'd0, imem_req}, 32'd1);
    end

    // Recovery after reset
    run_instr(32'h2004_0004, 2'b00, 32'h0, 0, 0, 1'b0);
    check("recover_retired", retired, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
